// File: rtl/user_id_enroller_pkg.sv
// Shared definitions for the user ID enroller.
//   state_t       : controller states
//   err_t         : result codes reported with done
//   SLOTS         : number of 4-digit ID slots in the 32-word store
//   DIGITS_PER_ID : digits per ID (one store word each)
//   TERMINATOR    : slot value that ends the ID list
//   id_digit()    : digit of a 16-bit ID, position 0 = most significant
package user_id_enroller_pkg;

  localparam int unsigned SLOTS         = 8;
  localparam int unsigned DIGITS_PER_ID = 4;
  localparam logic [15:0] TERMINATOR    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COLLECT    = 3'd1,
    ST_SCAN_ADDR  = 3'd2,
    ST_SCAN_CAP   = 3'd3,
    ST_CHECK      = 3'd4,
    ST_WRITE_TERM = 3'd5,
    ST_WRITE_ID   = 3'd6,
    ST_FINISH     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_DUP      = 2'd1,
    ERR_FULL     = 2'd2,
    ERR_RESERVED = 2'd3
  } err_t;

  function automatic logic [3:0] id_digit(input logic [15:0] id, input logic [1:0] pos);
    logic [3:0] d;
    case (pos)
      2'd0:    d = id[15:12];
      2'd1:    d = id[11:8];
      2'd2:    d = id[7:4];
      default: d = id[3:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/user_id_enroller_if.sv
// ID store bus between the enroller and the 32x4 store.
//   ram_addr  : word address
//   ram_wdata : write data
//   ram_we    : write enable
//   ram_rdata : read data, valid one cycle after ram_addr
// master = enroller side, slave = store side.
interface user_id_enroller_if;

  logic [4:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       ram_we;
  logic [3:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    output ram_rdata
  );

endinterface

// File: rtl/user_id_enroller_id_ram.sv
// ID store model: 32 words x 4 bits, synchronous write, registered read.
// A read of a word being written in the same cycle returns the old value.
//   clk : clock
//   bus : store side of the ID store bus
module id_ram (
  input logic               clk,
  user_id_enroller_if.slave bus
);

  logic [3:0] mem [32];

  always_ff @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

endmodule

// File: rtl/user_id_enroller.sv
// User ID enroller: collects a 4-digit ID, scans the ID store for a duplicate
// or the list terminator, then appends the ID (terminator moved first).
//   clk, rst        : clock, synchronous active-low reset
//   enroll_start    : one-cycle request to begin an enrollment (ignored when busy)
//   game_enter      : digit strobe, user_digit valid in the same cycle
//   user_digit      : entered digit
//   ram             : ID store bus (master side)
//   busy            : high outside IDLE
//   done            : one-cycle pulse at the end of every enrollment
//   error           : result code, valid with done, held until next enroll_start
//   new_internal_id : base word address of the written slot, valid when error=0
module user_id_enroller
  import user_id_enroller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enroll_start,
  input  logic                game_enter,
  input  logic [3:0]          user_digit,
  user_id_enroller_if.master  ram,
  output logic                busy,
  output logic                done,
  output logic [1:0]          error,
  output logic [4:0]          new_internal_id
);

  localparam logic [2:0] LAST_K     = 3'(SLOTS - 1);
  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS_PER_ID - 1);

  state_t      state;
  logic [15:0] entry;
  logic [15:0] slot;
  logic [15:0] entry_next;
  logic [1:0]  dcnt;
  logic [1:0]  idx;
  logic [2:0]  k;
  err_t        err_q;
  logic [4:0]  nid_q;

  assign entry_next      = {entry[11:0], user_digit};
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_FINISH);
  assign error           = err_q;
  assign new_internal_id = nid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      entry <= '0;
      slot  <= '0;
      dcnt  <= '0;
      idx   <= '0;
      k     <= '0;
      err_q <= ERR_OK;
      nid_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enroll_start) begin
            dcnt  <= '0;
            err_q <= ERR_OK;
            nid_q <= '0;
            state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (game_enter) begin
            entry <= entry_next;
            dcnt  <= dcnt + 2'd1;
            if (dcnt == LAST_DIGIT) begin
              // The reserved value is decided on the assembled entry so no
              // store access is ever started for it.
              if (entry_next == TERMINATOR) begin
                err_q <= ERR_RESERVED;
                state <= ST_FINISH;
              end else begin
                k     <= '0;
                idx   <= '0;
                state <= ST_SCAN_ADDR;
              end
            end
          end
        end

        ST_SCAN_ADDR: state <= ST_SCAN_CAP;

        ST_SCAN_CAP: begin
          slot  <= {slot[11:0], ram.ram_rdata};
          idx   <= idx + 2'd1;
          state <= (idx == LAST_DIGIT) ? ST_CHECK : ST_SCAN_ADDR;
        end

        // idx has wrapped back to 0 here, ready for the write phases.
        ST_CHECK: begin
          if (slot == entry) begin
            err_q <= ERR_DUP;
            state <= ST_FINISH;
          end else if (slot == TERMINATOR) begin
            if (k != LAST_K) begin
              state <= ST_WRITE_TERM;
            end else begin
              err_q <= ERR_FULL;
              state <= ST_FINISH;
            end
          end else if (k == LAST_K) begin
            err_q <= ERR_FULL;
            state <= ST_FINISH;
          end else begin
            k     <= k + 3'd1;
            state <= ST_SCAN_ADDR;
          end
        end

        ST_WRITE_TERM: begin
          idx <= idx + 2'd1;
          if (idx == LAST_DIGIT) begin
            state <= ST_WRITE_ID;
          end
        end

        ST_WRITE_ID: begin
          idx <= idx + 2'd1;
          if (idx == LAST_DIGIT) begin
            nid_q <= {k, 2'b00};
            err_q <= ERR_OK;
            state <= ST_FINISH;
          end
        end

        ST_FINISH: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Store bus is decoded from state so ram_we drops on the same edge the
  // state returns to IDLE (including on reset).
  always_comb begin
    ram.ram_addr  = '0;
    ram.ram_wdata = '0;
    ram.ram_we    = 1'b0;
    case (state)
      ST_SCAN_ADDR: begin
        ram.ram_addr = {k, idx};
      end
      ST_WRITE_TERM: begin
        ram.ram_addr  = {k + 3'd1, idx};
        ram.ram_wdata = 4'hF;
        ram.ram_we    = 1'b1;
      end
      ST_WRITE_ID: begin
        ram.ram_addr  = {k, idx};
        ram.ram_wdata = id_digit(entry, idx);
        ram.ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_user_id_enroller.sv
// Self-checking bench for user_id_enroller with a scoreboard and reference model.
module tb_user_id_enroller;
  import user_id_enroller_pkg::*;

  localparam int LIMIT = SLOTS * 9 + 8 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enroll_start = 1'b0;
  logic       game_enter = 1'b0;
  logic [3:0] user_digit = '0;
  logic       busy, done;
  logic [1:0] error;
  logic [4:0] new_internal_id;

  logic       pre = 1'b0;
  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [3:0] pre_wdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_id_enroller_if dut_bus ();
  user_id_enroller_if ram_bus ();

  assign ram_bus.ram_addr  = pre ? pre_addr  : dut_bus.ram_addr;
  assign ram_bus.ram_wdata = pre ? pre_wdata : dut_bus.ram_wdata;
  assign ram_bus.ram_we    = pre ? pre_we    : dut_bus.ram_we;
  assign dut_bus.ram_rdata = ram_bus.ram_rdata;

  user_id_enroller dut (
    .clk             (clk),
    .rst             (rst),
    .enroll_start    (enroll_start),
    .game_enter      (game_enter),
    .user_digit      (user_digit),
    .ram             (dut_bus),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .new_internal_id (new_internal_id)
  );

  id_ram u_ram (
    .clk (clk),
    .bus (ram_bus)
  );

  typedef struct packed {
    logic [1:0] err;
    logic [4:0] nid;
  } res_t;

  typedef struct packed {
    logic [4:0] a;
    logic [3:0] d;
  } wr_t;

  res_t exp_q[$];
  wr_t  wr_q[$];
  logic [3:0] mdl [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] mslot(input int k);
    return {mdl[4*k], mdl[4*k+1], mdl[4*k+2], mdl[4*k+3]};
  endfunction

  task automatic set_slot(input int k, input logic [15:0] v);
    for (int j = 0; j < 4; j++) mdl[4*k+j] = 4'(v >> (4*(3-j)));
  endtask

  task automatic push_wr(input int a, input logic [3:0] d);
    wr_t w;
    w.a = 5'(a);
    w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic predict(input logic [15:0] e, output res_t r);
    bit found;
    r.err = ERR_OK;
    r.nid = '0;
    found = 1'b0;
    if (e == TERMINATOR) begin
      r.err = ERR_RESERVED;
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        if (!found) begin
          if (mslot(k) == e) begin
            r.err = ERR_DUP;
            found = 1'b1;
          end else if (mslot(k) == TERMINATOR) begin
            found = 1'b1;
            if (k < SLOTS - 1) begin
              r.nid = 5'(4*k);
              for (int j = 0; j < 4; j++) push_wr(4*k+4+j, 4'hF);
              for (int j = 0; j < 4; j++) push_wr(4*k+j, 4'(e >> (4*(3-j))));
              set_slot(k+1, TERMINATOR);
              set_slot(k, e);
            end else begin
              r.err = ERR_FULL;
            end
          end
        end
      end
      if (!found) r.err = ERR_FULL;
    end
  endtask

  // ---------------- store backdoor ----------------
  task automatic fill_garbage();
    for (int a = 0; a < 32; a++) mdl[a] = 4'($urandom);
  endtask

  task automatic load_ram();
    pre = 1'b1;
    pre_we = 1'b1;
    for (int a = 0; a < 32; a++) begin
      pre_addr  = 5'(a);
      pre_wdata = mdl[a];
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    pre = 1'b0;
  endtask

  task automatic readback(input int k);
    logic [15:0] v;
    v = '0;
    pre = 1'b1;
    pre_we = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pre_addr = 5'(4*k+j);
      @(posedge clk); #1;
      v = {v[11:0], ram_bus.ram_rdata};
    end
    pre = 1'b0;
    chk($sformatf("slot%0d_readback", k), 32'(v), 32'(mslot(k)));
  endtask

  // ---------------- monitor ----------------
  res_t mon_r;
  wr_t  mon_w;

  always @(negedge clk) begin
    if (rst) begin
      if (dut_bus.ram_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                   dut_bus.ram_addr, dut_bus.ram_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          chk("write_addr_data", {23'b0, dut_bus.ram_addr, dut_bus.ram_wdata}, {23'b0, mon_w.a, mon_w.d});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: error %0d, none expected", error);
        end else begin
          mon_r = exp_q.pop_front();
          chk("error", 32'(error), 32'(mon_r.err));
          if (mon_r.err == ERR_OK) chk("new_internal_id", 32'(new_internal_id), 32'(mon_r.nid));
          chk("writes_pending_at_done", 32'(wr_q.size()), 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_digits(input logic [15:0] e);
    for (int d = 0; d < 4; d++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      game_enter = 1'b1;
      user_digit = 4'(e >> (4*(3-d)));
      @(posedge clk); #1;
      game_enter = 1'b0;
    end
  endtask

  task automatic enroll(input logic [15:0] e, input bit noise, input bit poke);
    res_t r;
    int lat;
    logic [4:0] a0;
    predict(e, r);
    exp_q.push_back(r);
    if (noise) begin
      game_enter = 1'b1;
      user_digit = 4'($urandom);
      @(posedge clk); #1;
      game_enter = 1'b0;
    end
    enroll_start = 1'b1;
    game_enter = noise;
    user_digit = 4'($urandom);
    @(posedge clk); #1;
    enroll_start = 1'b0;
    game_enter = 1'b0;
    send_digits(e);
    a0 = dut_bus.ram_addr;
    lat = 0;
    if (poke && e != TERMINATOR) begin
      enroll_start = 1'b1;
      @(posedge clk); #1;
      enroll_start = 1'b0;
      lat = 1;
    end
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_within_limit", 32'(done), 32'd1);
    if (e == TERMINATOR) begin
      chk("reserved_latency_le2", 32'(lat <= 2), 32'd1);
      chk("reserved_addr_stable", 32'(dut_bus.ram_addr), 32'(a0));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("error_hold", 32'(error), 32'(r.err));
    if (r.err == ERR_OK) chk("nid_hold", 32'(new_internal_id), 32'(r.nid));
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic preload_a();
    fill_garbage();
    set_slot(0, 16'h0000);
    set_slot(1, 16'h1234);
    set_slot(2, TERMINATOR);
    load_ram();
  endtask

  initial begin
    int to;
    logic [15:0] e;
    int kk;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_nid", 32'(new_internal_id), 32'd0);
    chk("rst_we", 32'(dut_bus.ram_we), 32'd0);
    chk("rst_addr", 32'(dut_bus.ram_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // duplicate with IDLE digit noise and a start pulse during the scan,
    // then a successful append, then the reserved value
    preload_a();
    enroll(16'h1234, 1'b1, 1'b1);
    enroll(16'h5678, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) readback(k);
    enroll(TERMINATOR, 1'b0, 1'b0);

    // full: terminator in the last slot
    fill_garbage();
    for (int k = 0; k < SLOTS - 1; k++) set_slot(k, 16'(16'h0100 + k * 16'h1111));
    set_slot(SLOTS - 1, TERMINATOR);
    load_ram();
    enroll(16'h9999, 1'b0, 1'b1);

    // full: no terminator anywhere
    fill_garbage();
    for (int k = 0; k < SLOTS; k++) set_slot(k, 16'(16'hA000 + k));
    load_ram();
    enroll(16'h0BCD, 1'b1, 1'b0);

    // reset during the second terminator write
    preload_a();
    enroll_start = 1'b1;
    @(posedge clk); #1;
    enroll_start = 1'b0;
    send_digits(16'h4321);
    push_wr(12, 4'hF);
    push_wr(13, 4'hF);
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!(dut_bus.ram_we && dut_bus.ram_addr == 5'd13) && to < 100);
    chk("abort_point_reached", 32'(to < 100), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_we", 32'(dut_bus.ram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_writes_pending", 32'(wr_q.size()), 32'd0);
    rst = 1'b1;
    mdl[12] = 4'hF;
    mdl[13] = 4'hF;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) readback(k);

    // randomized enrollments from an empty list until it fills
    fill_garbage();
    set_slot(0, TERMINATOR);
    load_ram();
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 9))
        0: e = TERMINATOR;
        1, 2, 3: begin
          kk = int'($urandom_range(0, SLOTS - 1));
          e = mslot(kk);
        end
        default: e = 16'($urandom);
      endcase
      if (e == TERMINATOR && n % 5 != 0) e = 16'h0F0F;
      enroll(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < SLOTS; k++) readback(k);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("write_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
